// File: rtl/add_sub.sv
// add_sub: registered ripple-carry adder/subtractor.
// cin selects add (0) or subtract (1) and also serves as the carry into
// bit 0, so subtraction is x + ~y + 1 through the same carry chain.
// sum, cout and v come straight from flops, one cycle after x/y/cin are sampled.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // One-bit sum and carry; carry is generate OR (propagate AND carry-in)
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (ci & (a ^ b));
  end

endmodule

module add_sub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             v
);

  logic [WIDTH-1:0] yeff;
  logic [WIDTH-1:0] rawsum;
  logic [WIDTH:0]   carry;

  // Invert y in subtract mode and inject cin as the carry into bit 0
  always_comb begin
    yeff     = y ^ {WIDTH{cin}};
    carry[0] = cin;
  end

  // Ripple chain: carry out of cell i feeds carry in of cell i+1
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder u_fa (
      .a  (x[i]),
      .b  (yeff[i]),
      .ci (carry[i]),
      .s  (rawsum[i]),
      .co (carry[i+1])
    );
  end

  // Result register; synchronous active-low reset clears everything, so a
  // result still in flight when reset hits is dropped rather than presented
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
      v    <= 1'b0;
    end else begin
      sum  <= rawsum;
      cout <= carry[WIDTH];
      v    <= carry[WIDTH] ^ carry[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_add_sub.sv
// tb_add_sub: directed vector table, exhaustive sweep against a behavioural
// model, and hand-written reset sequences for add_sub (WIDTH=4).

module tb_add_sub;

  logic       clk;
  logic       rst_n;
  logic [3:0] x;
  logic [3:0] y;
  logic       cin;
  logic [3:0] sum;
  logic       cout;
  logic       v;

  int checks;
  int errors;

  typedef struct {
    string      name;
    logic [3:0] x;
    logic [3:0] y;
    logic       cin;
    logic [3:0] esum;
    logic       ecout;
    logic       ev;
  } vec_t;

  vec_t vecs[8];

  add_sub #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (x),
    .y     (y),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout),
    .v     (v)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: sim time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: plain arithmetic total and sign-rule overflow
  function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic m);
    logic [3:0] bb;
    logic [4:0] t;
    logic       ovf;
    bb  = b ^ {4{m}};
    t   = {1'b0, a} + {1'b0, bb} + {4'b0, m};
    ovf = (a[3] == bb[3]) && (t[3] != a[3]);
    return {t, ovf};
  endfunction

  // Drive inputs on the falling edge, then let the next rising edge sample them
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                               input logic m, input logic rn);
    @(negedge clk);
    x     = a;
    y     = b;
    cin   = m;
    rst_n = rn;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] esum,
                             input logic ecout, input logic ev);
    checks++;
    if (sum !== esum || cout !== ecout || v !== ev) begin
      errors++;
      $display("[TB] FAIL %s: got sum=%b cout=%b v=%b, expected sum=%b cout=%b v=%b",
               name, sum, cout, v, esum, ecout, ev);
    end
  endtask

  initial begin
    logic [5:0] m;

    checks = 0;
    errors = 0;
    x      = 4'b0;
    y      = 4'b0;
    cin    = 1'b0;
    rst_n  = 1'b0;

    vecs[0] = '{"add_3p4",      4'b0011, 4'b0100, 1'b0, 4'b0111, 1'b0, 1'b0};
    vecs[1] = '{"add_ovf_7p1",  4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1};
    vecs[2] = '{"add_ovf_8p8",  4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1};
    vecs[3] = '{"sub_3m5",      4'b0011, 4'b0101, 1'b1, 4'b1110, 1'b0, 1'b0};
    vecs[4] = '{"sub_0m0",      4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0};
    vecs[5] = '{"sub_ovf_8m1",  4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1, 1'b1};
    vecs[6] = '{"sub_ovf_7mm1", 4'b0111, 4'b1111, 1'b1, 4'b1000, 1'b0, 1'b1};
    vecs[7] = '{"add_15p1",     4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0};

    // Reset holds outputs at zero regardless of operands
    applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b0);
    checkOutput("reset_hold_a", 4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0111, 4'b1000, 1'b0, 1'b0);
    checkOutput("reset_hold_b", 4'b0000, 1'b0, 1'b0);

    // Directed table; consecutive rows flip cin with no idle cycle between
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].x, vecs[i].y, vecs[i].cin, 1'b1);
      checkOutput(vecs[i].name, vecs[i].esum, vecs[i].ecout, vecs[i].ev);
    end

    // Exhaustive sweep, one operand pair per cycle
    for (int c = 0; c < 2; c++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          applyStimulus(4'(a), 4'(b), 1'(c), 1'b1);
          m = model(4'(a), 4'(b), 1'(c));
          checkOutput("sweep", m[4:1], m[5], m[0]);
        end
      end
    end

    // Reset with 7+7 waiting, then release: first unreset edge yields 1110
    applyStimulus(4'b0111, 4'b0111, 1'b0, 1'b0);
    checkOutput("rst_7p7_assert", 4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0111, 4'b0111, 1'b0, 1'b1);
    checkOutput("rst_7p7_release", 4'b1110, 1'b0, 1'b1);

    // Reset dropped between edges must not disturb the held result
    @(negedge clk);
    rst_n = 1'b0;
    x     = 4'b0011;
    y     = 4'b0100;
    #2;
    checkOutput("rst_between_edges", 4'b1110, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("rst_midstream_clear", 4'b0000, 1'b0, 1'b0);

    // Pending operands at reset are discarded; next result is from new inputs
    applyStimulus(4'b1000, 4'b0001, 1'b1, 1'b1);
    checkOutput("post_rst_fresh", 4'b0111, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_sub.md
ADD_SUB -- requirements
Module: add_sub

Interface
REQ-001 Parameter WIDTH, default 4, operand and result width in bits; all requirements use WIDTH=4 unless stated.
REQ-002 clk  input  1  rising-edge clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 x  input  WIDTH  operand A, two's complement or unsigned.
REQ-005 y  input  WIDTH  operand B, two's complement or unsigned.
REQ-006 cin  input  1  mode select: 0 = add (x+y), 1 = subtract (x-y).
REQ-007 sum  output  WIDTH  registered result bits [WIDTH-1:0].
REQ-008 cout  output  1  registered carry out of MSB.
REQ-009 v  output  1  registered signed-overflow flag.

Function
REQ-010 The block SHALL compute s = x + (y XOR {WIDTH{cin}}) + cin, i.e. x+y when cin=0 and x+~y+1 (x-y) when cin=1.
REQ-011 The datapath SHALL be a WIDTH-stage ripple-carry chain of full-adder cells, with cin as the carry into bit 0.
REQ-012 cout SHALL equal the carry out of bit WIDTH-1; in subtract mode cout=1 means no borrow (x >= y unsigned), cout=0 means borrow.
REQ-013 v SHALL equal carry-into-MSB XOR carry-out-of-MSB; equivalently v=1 iff the signed result falls outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-014 {cout,sum} SHALL form the (WIDTH+1)-bit unsigned total of the operation as defined in REQ-010.
REQ-015 Inputs SHALL be sampled every rising clk edge with no handshake; sum, cout and v SHALL reflect the sampled operands exactly one cycle later (latency 1, throughput 1 per cycle).
REQ-016 Outputs SHALL be driven only from registers; no combinational path from inputs to outputs.
REQ-017 Changing cin between consecutive cycles SHALL take effect on the very next registered result with no dead cycle.
REQ-018 Operands and mode SHALL be treated identically for all values, including -2^(WIDTH-1) (e.g. 1000) and all-ones; no saturation or clamping.

Reset
REQ-019 While rst_n=0 at a rising clk edge, sum SHALL become 0, cout 0, v 0, regardless of x, y, cin.
REQ-020 Reset SHALL have no effect between clock edges (synchronous only).
REQ-021 On the first rising edge with rst_n=1, the block SHALL register the current inputs; the valid result appears on the following cycle.
REQ-022 Reset asserted mid-stream SHALL discard the pending result; no stale result is presented after reset release.

Verification
REQ-023 Add, x=0011, y=0100, cin=0 -> one cycle later sum=0111, cout=0, v=0.
REQ-024 Add overflow, x=0111, y=0001, cin=0 -> sum=1000, cout=0, v=1; and x=1000, y=1000, cin=0 -> sum=0000, cout=1, v=1.
REQ-025 Subtract, x=0011, y=0101, cin=1 -> sum=1110 (-2), cout=0 (borrow), v=0; x=0000, y=0000, cin=1 -> sum=0000, cout=1, v=0.
REQ-026 Subtract overflow, x=1000, y=0001, cin=1 -> sum=0111, cout=1, v=1; x=0111, y=1111, cin=1 -> sum=1000, cout=0, v=1.
REQ-027 Exhaustive sweep: all 16x16 x/y pairs with cin=0, then all with cin=1, one pair per cycle -> each registered {cout,sum} and v match REQ-010..REQ-013 one cycle after application.
REQ-028 Reset: drive x=0111, y=0111, cin=0, assert rst_n=0 for one edge -> sum=0000, cout=0, v=0 that cycle; release -> sum=1110, v=1, cout=0 one cycle after the first unreset edge.
